// File: rtl/mu0_ctrl_if.sv
// Control bundle between the MU0 sequencer and its datapath: decode inputs
// from IR/ACC, mux selects, ALU function, register enables and memory strobes.
interface mu0_ctrl_if;
  logic [3:0] opcode;
  logic       n;
  logic       z;
  logic       a_sel;
  logic       x_sel;
  logic       y_sel;
  logic [1:0] m;
  logic       acc_en;
  logic       pc_en;
  logic       ir_en;
  logic       acc_oe;
  logic       rd;
  logic       wr;
  logic       halted;

  modport master (
    input  opcode, n, z,
    output a_sel, x_sel, y_sel, m, acc_en, pc_en, ir_en, acc_oe, rd, wr, halted
  );

  modport slave (
    output opcode, n, z,
    input  a_sel, x_sel, y_sel, m, acc_en, pc_en, ir_en, acc_oe, rd, wr, halted
  );
endinterface

// File: rtl/mu0_ctrl.sv
// MU0 sequencer: FETCH/EXECUTE/HALT state machine decoding the datapath controls.
// Define MU0_ILLEGAL_HALT_EN to make opcodes 8-F halt instead of acting as NOPs.
module mu0_ctrl (
  input  logic              clk,
  input  logic              rst,
  mu0_ctrl_if.master        bus
);

  // HALT sits on its own bit so halted comes straight off a flop.
  typedef enum logic [1:0] {
    FETCH   = 2'b00,
    EXECUTE = 2'b01,
    HALT    = 2'b10
  } state_t;

  state_t state;
  state_t state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  assign bus.halted = state[1];

  always_comb begin
    state_nxt  = state;
    bus.a_sel  = 1'b0;
    bus.x_sel  = 1'b0;
    bus.y_sel  = 1'b0;
    bus.m      = 2'b00;
    bus.acc_en = 1'b0;
    bus.pc_en  = 1'b0;
    bus.ir_en  = 1'b0;
    bus.acc_oe = 1'b0;
    bus.rd     = 1'b0;
    bus.wr     = 1'b0;

    unique case (state)
      FETCH: begin
        bus.rd    = 1'b1;
        bus.ir_en = 1'b1;
        bus.x_sel = 1'b1;
        bus.m     = 2'b10;
        bus.pc_en = 1'b1;
        state_nxt = EXECUTE;
      end
      EXECUTE: begin
        bus.a_sel = 1'b1;
        state_nxt = FETCH;
        case (bus.opcode)
          4'h0: begin
            bus.rd     = 1'b1;
            bus.acc_en = 1'b1;
          end
          4'h1: begin
            bus.wr     = 1'b1;
            bus.acc_oe = 1'b1;
          end
          4'h2: begin
            bus.rd     = 1'b1;
            bus.m      = 2'b01;
            bus.acc_en = 1'b1;
          end
          4'h3: begin
            bus.rd     = 1'b1;
            bus.m      = 2'b11;
            bus.acc_en = 1'b1;
          end
          4'h4: begin
            bus.y_sel = 1'b1;
            bus.pc_en = 1'b1;
          end
          4'h5: begin
            bus.y_sel = 1'b1;
            bus.pc_en = ~bus.n;
          end
          4'h6: begin
            bus.y_sel = 1'b1;
            bus.pc_en = ~bus.z;
          end
          4'h7: state_nxt = HALT;
          default: begin
`ifdef MU0_ILLEGAL_HALT_EN
            state_nxt = HALT;
`else
            state_nxt = FETCH;
`endif
          end
        endcase
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase

    // Reset aborts any in-flight access; the selects already show FETCH values.
    if (rst) begin
      bus.acc_en = 1'b0;
      bus.pc_en  = 1'b0;
      bus.ir_en  = 1'b0;
      bus.acc_oe = 1'b0;
      bus.rd     = 1'b0;
      bus.wr     = 1'b0;
    end
  end

endmodule

// File: tb/tb_mu0_ctrl.sv
// Directed and random bench for mu0_ctrl, scoreboarding the full control vector.
module tb_mu0_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  mu0_ctrl_if bus ();
  mu0_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  localparam int ST_F = 0, ST_E = 1, ST_H = 2;
  // vector: a_sel x_sel y_sel m[1:0] acc_en pc_en ir_en acc_oe rd wr halted
  localparam logic [11:0] MASK_ALL  = 12'hFFF;
  localparam logic [11:0] MASK_HALT = 12'b0000_0111_1111;

  typedef struct {
    logic [11:0] v;
    logic [11:0] mask;
  } exp_t;

  exp_t exp_q[$];
  int   mstate = ST_F;

  function automatic logic [11:0] pack_obs();
    return {bus.a_sel, bus.x_sel, bus.y_sel, bus.m, bus.acc_en, bus.pc_en,
            bus.ir_en, bus.acc_oe, bus.rd, bus.wr, bus.halted};
  endfunction

  function automatic exp_t model_out(input int st, input logic [3:0] op,
                                     input logic nn, input logic zz, input logic r);
    logic a, x, y, acc, pc, ir, oe, rdv, wrv, h;
    logic [1:0] mm;
    exp_t e;
    {a, x, y, acc, pc, ir, oe, rdv, wrv, h} = '0;
    mm = 2'b00;
    e.mask = MASK_ALL;
    if (r || st == ST_F) begin
      rdv = 1; ir = 1; x = 1; mm = 2'b10; pc = 1;
      if (r) {acc, pc, ir, oe, rdv, wrv} = '0;
    end else if (st == ST_E) begin
      a = 1;
      if      (op == 4'd0) begin rdv = 1; acc = 1; end
      else if (op == 4'd1) begin wrv = 1; oe = 1; end
      else if (op == 4'd2) begin rdv = 1; mm = 2'b01; acc = 1; end
      else if (op == 4'd3) begin rdv = 1; mm = 2'b11; acc = 1; end
      else if (op == 4'd4) begin y = 1; pc = 1; end
      else if (op == 4'd5) begin y = 1; pc = ~nn; end
      else if (op == 4'd6) begin y = 1; pc = ~zz; end
    end else begin
      h = 1;
      e.mask = MASK_HALT;
    end
    e.v = {a, x, y, mm, acc, pc, ir, oe, rdv, wrv, h};
    return e;
  endfunction

  function automatic int model_next(input int st, input logic [3:0] op);
    if (st == ST_F) return ST_E;
    if (st == ST_H) return ST_H;
    if (op == 4'd7) return ST_H;
`ifdef MU0_ILLEGAL_HALT_EN
    if (op >= 4'd8) return ST_H;
`endif
    return ST_F;
  endfunction

  task automatic check_out(input string tag);
    exp_t e;
    logic [11:0] obs;
    obs = pack_obs();
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert ((obs & e.mask) === (e.v & e.mask)) else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", tag, obs & e.mask, e.v & e.mask);
      end
    end
  endtask

  task automatic check_excl(input string tag);
    tests++;
    assert (!(bus.rd && bus.wr)) else begin
      fails++;
      $error("FAIL %s rd/wr observed=%b%b expected not both 1", tag, bus.rd, bus.wr);
    end
    tests++;
    assert (!(bus.ir_en && bus.acc_en)) else begin
      fails++;
      $error("FAIL %s ir_en/acc_en observed=%b%b expected not both 1", tag, bus.ir_en, bus.acc_en);
    end
  endtask

  // One clock: drive at posedge+1, compare at negedge, advance the model.
  task automatic cycle(input logic [3:0] op, input logic nn, input logic zz, input string tag);
    bus.opcode = op; bus.n = nn; bus.z = zz;
    exp_q.push_back(model_out(mstate, op, nn, zz, 1'b0));
    @(negedge clk);
    check_out(tag);
    @(posedge clk);
    #1;
    mstate = model_next(mstate, op);
  endtask

  task automatic reset_pulse(input string tag);
    rst = 1'b1;
    mstate = ST_F;
    exp_q.push_back(model_out(ST_F, bus.opcode, bus.n, bus.z, 1'b1));
    #1 check_out(tag);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.opcode = 4'd0; bus.n = 1'b0; bus.z = 1'b0;
    #3;
    exp_q.push_back(model_out(ST_F, 4'd0, 1'b0, 1'b0, 1'b1));
    check_out("reset_state");
    @(posedge clk);
    #1 rst = 1'b0;
    mstate = ST_F;

    cycle(4'd0, 0, 0, "lda_fetch");
    cycle(4'd0, 0, 0, "lda_exec");
    cycle(4'd1, 0, 0, "sta_fetch");
    cycle(4'd1, 0, 0, "sta_exec");
    cycle(4'd2, 0, 0, "add_fetch");
    cycle(4'd2, 0, 0, "add_exec");
    cycle(4'd3, 0, 0, "sub_fetch");
    cycle(4'd3, 1, 1, "sub_exec");
    cycle(4'd4, 0, 0, "jmp_fetch");
    cycle(4'd4, 1, 1, "jmp_exec");
    cycle(4'd5, 0, 0, "jge_fetch");
    cycle(4'd5, 0, 1, "jge_n0");
    cycle(4'd5, 1, 0, "jge_fetch2");
    cycle(4'd5, 1, 0, "jge_n1");
    cycle(4'd6, 0, 0, "jne_fetch");
    cycle(4'd6, 1, 0, "jne_z0");
    cycle(4'd6, 0, 1, "jne_fetch2");
    cycle(4'd6, 0, 1, "jne_z1");

    // Opcode 9: NOP by default, halt when the illegal-halt build is selected.
    cycle(4'd9, 0, 0, "ill_fetch");
    cycle(4'd9, 0, 0, "ill_exec");
    cycle(4'd0, 0, 0, "after_ill");
    if (mstate == ST_H) reset_pulse("ill_reset");
    else cycle(4'd0, 0, 0, "after_ill_exec");

    // Reset in the middle of an ADD execute.
    cycle(4'd2, 0, 0, "rst_add_fetch");
    bus.opcode = 4'd2;
    exp_q.push_back(model_out(mstate, 4'd2, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    check_out("rst_add_exec");
    #1 rst = 1'b1;
    mstate = ST_F;
    exp_q.push_back(model_out(ST_F, 4'd2, 1'b0, 1'b0, 1'b1));
    #1 check_out("rst_async");
    tests++;
    assert (bus.acc_en === 1'b0) else begin
      fails++;
      $error("FAIL rst_acc_en observed=%b expected=0", bus.acc_en);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    cycle(4'd2, 0, 0, "post_rst_fetch");
    cycle(4'd2, 0, 0, "post_rst_exec");

    // STP then 10 cycles of changing opcodes while halted.
    cycle(4'd7, 0, 0, "stp_fetch");
    cycle(4'd7, 0, 0, "stp_exec");
    for (int i = 0; i < 10; i++)
      cycle(4'(i), 1'(i), 1'(i >> 1), "halt_hold");
    reset_pulse("halt_reset");
    cycle(4'd0, 0, 0, "halt_exit_fetch");
    cycle(4'd0, 0, 0, "halt_exit_exec");

    for (int i = 0; i < 1000; i++) begin
      if (mstate == ST_H) begin
        reset_pulse("rand_reset");
      end else begin
        bus.opcode = 4'($urandom_range(0, 15));
        bus.n = 1'($urandom_range(0, 1));
        bus.z = 1'($urandom_range(0, 1));
        exp_q.push_back(model_out(mstate, bus.opcode, bus.n, bus.z, 1'b0));
        @(negedge clk);
        check_out("rand");
        check_excl("rand_excl");
        @(posedge clk);
        #1;
        mstate = model_next(mstate, bus.opcode);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mu0_ctrl.md
MU0_CTRL -- requirements
Module: mu0_ctrl

Interface
REQ-001 Parameters: none.
REQ-002 Clk  input  1  system clock; all state changes on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Opcode  input  4  instruction opcode, IR[15:12], valid in EXECUTE.
REQ-005 N  input  1  accumulator negative flag, ACC[15].
REQ-006 Z  input  1  accumulator zero flag, ACC==0.
REQ-007 A_sel  output  1  address mux: 0 = PC, 1 = IR[11:0].
REQ-008 X_sel  output  1  ALU X mux: 0 = ACC, 1 = PC.
REQ-009 Y_sel  output  1  ALU Y mux: 0 = memory data, 1 = IR[11:0].
REQ-010 M  output  2  ALU function: 00 = Y, 01 = X+Y, 10 = X+1, 11 = X-Y.
REQ-011 ACC_En / PC_En / IR_En  output  1 each  register load enables, sampled by mu0_reg12/reg16 instances on the next rising Clk.
REQ-012 ACC_oe  output  1  drives ACC onto the memory write-data bus.
REQ-013 Rd / Wr  output  1 each  memory read / write strobes.
REQ-014 Halted  output  1  high while in HALT.

Function
REQ-015 The FSM SHALL have three states: FETCH, EXECUTE and HALT. It SHALL be held in a register and SHALL have no other state elements.
REQ-016 FETCH SHALL drive A_sel=0, Rd=1, IR_En=1, X_sel=1, M=10 and PC_En=1, with all other outputs 0. The next state SHALL be EXECUTE unconditionally.
REQ-017 Every EXECUTE cycle SHALL drive A_sel=1 and SHALL return to FETCH, except where stated otherwise. Outputs not listed for an opcode SHALL be 0.
REQ-018 LDA (0): Rd=1, Y_sel=0, M=00, ACC_En=1.
REQ-019 STA (1): Wr=1, ACC_oe=1.
REQ-020 ADD (2): Rd=1, X_sel=0, Y_sel=0, M=01, ACC_En=1.
REQ-021 SUB (3): Rd=1, X_sel=0, Y_sel=0, M=11, ACC_En=1.
REQ-022 JMP (4): Y_sel=1, M=00, PC_En=1.
REQ-023 JGE (5): Y_sel=1, M=00, PC_En = ~N.
REQ-024 JNE (6): Y_sel=1, M=00, PC_En = ~Z.
REQ-025 STP (7): all enables and strobes 0; the next state SHALL be HALT.
REQ-026 Outputs SHALL be combinational functions of the state, Opcode, N and Z. The only registered output SHALL be Halted.
REQ-027 The latency of each instruction SHALL be exactly 2 cycles: FETCH then EXECUTE.
REQ-028 In HALT, all enables, Rd and Wr SHALL be 0. The FSM SHALL stay in HALT until Reset is asserted, whatever Opcode, N and Z do.
REQ-029 Rd and Wr SHALL never be high in the same cycle. IR_En and ACC_En SHALL never be high in the same cycle.

Reset
REQ-030 Asserting Reset SHALL immediately, with no clock edge needed, set the state to FETCH and Halted to 0.
REQ-031 While Reset is high, ACC_En, PC_En, IR_En, Rd, Wr and ACC_oe SHALL be forced to 0. All other outputs SHALL show their FETCH values.
REQ-032 Reset asserted in EXECUTE or HALT SHALL abort the instruction with no register enable active. The first rising Clk after Reset deasserts SHALL perform a FETCH.

Configuration
REQ-033 Macro MU0_ILLEGAL_HALT_EN SHALL control how opcodes 8 to F are handled:
- Defined: an EXECUTE with an opcode of 8 to F SHALL behave as STP and enter HALT.
- Undefined: such an EXECUTE SHALL be a NOP, with all enables and strobes 0, and SHALL return to FETCH.

Verification
REQ-034 Release Reset, then apply 2 Clk edges with Opcode=0 -> FETCH outputs Rd=1, IR_En=1, PC_En=1, M=10; then EXECUTE outputs A_sel=1, Rd=1, ACC_En=1, M=00; then back in FETCH.
REQ-035 EXECUTE with Opcode=5 -> N=0 gives PC_En=1; N=1 gives PC_En=0. EXECUTE with Opcode=6 -> Z=0 gives PC_En=1; Z=1 gives PC_En=0. Y_sel=1 and M=00 in all four cases.
REQ-036 EXECUTE with Opcode=7 -> Halted=1 after the edge. Then 10 Clk edges with Opcode cycling 0 to F -> all enables, Rd and Wr stay 0 and Halted stays 1.
REQ-037 Assert Reset mid-cycle in EXECUTE with Opcode=2 -> ACC_En=0 at once, without a clock edge. After release, the first edge is a FETCH.
REQ-038 EXECUTE with Opcode=9 -> with MU0_ILLEGAL_HALT_EN, Halted=1; without it, Halted=0 and the next state is FETCH, with no strobe asserted.
REQ-039 Run a random opcode and flag stream for 1000 cycles -> the REQ-029 exclusivity checks pass on every cycle.
